// File: rtl/down_timer_if.sv
// down_timer_if: control/status bundle for the down_timer block.
//   en, start, stop, pause, periodic, loadVal : controller -> timer
//   count, busy, done                          : timer -> controller
// master modport is the controlling side, slave modport is the timer.
interface down_timer_if #(
  parameter int unsigned N = 4
);
  logic         en;
  logic         start;
  logic         stop;
  logic         pause;
  logic         periodic;
  logic [N-1:0] loadVal;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  modport master (
    output en, start, stop, pause, periodic, loadVal,
    input  count, busy, done
  );

  modport slave (
    input  en, start, stop, pause, periodic, loadVal,
    output count, busy, done
  );
endinterface

// File: rtl/down_timer.sv
// down_timer: programmable down-counting timer with one-shot and periodic
// (auto-reload) modes, plus pause and stop controls.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : down_timer_if.slave
//          en       tick enable
//          start    pulse, loads loadVal / periodic and (re)starts
//          stop     pulse, aborts to IDLE with count cleared
//          pause    level, freezes the count while in RUN
//          periodic sampled with start, 1 = auto-reload
//          loadVal  start value, sampled with start
//          count    current count
//          busy     state is not IDLE
//          done     combinational expiry strobe
module down_timer #(
  parameter int unsigned N = 4
) (
  input logic            clk,
  input logic            rst,
  down_timer_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] count_q, count_n;
  logic [N-1:0] reload_q, reload_n;
  logic         mode_periodic_q, mode_periodic_n;
  logic         done_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      count_q         <= '0;
      reload_q        <= '0;
      mode_periodic_q <= 1'b0;
    end else begin
      state           <= state_n;
      count_q         <= count_n;
      reload_q        <= reload_n;
      mode_periodic_q <= mode_periodic_n;
    end
  end

  // Priority: stop > start > pause > en.
  always_comb begin
    state_n         = state;
    count_n         = count_q;
    reload_n        = reload_q;
    mode_periodic_n = mode_periodic_q;
    done_c          = 1'b0;

    if (bus.stop) begin
      state_n = IDLE;
      count_n = '0;
    end else if (bus.start) begin
      state_n         = RUN;
      count_n         = bus.loadVal;
      reload_n        = bus.loadVal;
      mode_periodic_n = bus.periodic;
    end else begin
      unique case (state)
        RUN: begin
          if (bus.pause) begin
            state_n = PAUSED;
          end else if (bus.en) begin
            if (count_q != '0) begin
              count_n = count_q - 1'b1;
            end else begin
              // Expiry on the tick where the count is already zero.
              done_c = 1'b1;
              if (mode_periodic_q) begin
                count_n = reload_q;
              end else begin
                state_n = IDLE;
              end
            end
          end
        end
        PAUSED: begin
          // The release cycle only returns to RUN; no tick is taken.
          if (!bus.pause) begin
            state_n = RUN;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  assign bus.count = count_q;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = done_c;

endmodule

// File: tb/tb_down_timer.sv
module tb_down_timer;

  localparam int unsigned N = 4;

  logic clk;
  logic rst;

  down_timer_if #(.N(N)) bus ();

  down_timer #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model in terms of "enabled ticks since load":
  // while running, count = reload - ticks; expiry when ticks == reload.
  bit m_busy;
  bit m_paused;
  bit m_per;
  int m_reload;
  int m_ticks;

  int done_seen;

  typedef struct {
    bit       en;
    bit       start;
    bit       stop;
    bit       pause;
    bit       periodic;
    int       lv;
    int       exp_count;
    bit       exp_busy;
    bit       exp_done;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_count();
    return m_busy ? (m_reload - m_ticks) : 0;
  endfunction

  function automatic bit model_done(input bit en, input bit start, input bit stop, input bit pause);
    return m_busy && !m_paused && !pause && en && (m_ticks == m_reload) && !start && !stop;
  endfunction

  task automatic model_step(input bit en, input bit start, input bit stop, input bit pause,
                            input bit periodic, input int lv);
    if (stop) begin
      m_busy = 0;
    end else if (start) begin
      m_busy   = 1;
      m_paused = 0;
      m_reload = lv;
      m_per    = periodic;
      m_ticks  = 0;
    end else if (m_busy) begin
      if (m_paused) begin
        if (!pause) m_paused = 0;
      end else if (pause) begin
        m_paused = 1;
      end else if (en) begin
        if (m_ticks == m_reload) begin
          if (m_per) m_ticks = 0;
          else       m_busy = 0;
        end else begin
          m_ticks++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_paused = 0;
    m_per    = 0;
    m_reload = 0;
    m_ticks  = 0;
  endtask

  // One clock cycle: drive after negedge, check, advance model, wait edges.
  task automatic cycle(input bit en, input bit start, input bit stop, input bit pause,
                       input bit periodic, input int lv);
    bit ed;
    bus.en       = en;
    bus.start    = start;
    bus.stop     = stop;
    bus.pause    = pause;
    bus.periodic = periodic;
    bus.loadVal  = lv[N-1:0];
    #1;
    ed = model_done(en, start, stop, pause);
    chk("count", int'(bus.count), model_count());
    chk("busy",  int'(bus.busy),  int'(m_busy));
    chk("done",  int'(bus.done),  int'(ed));
    if (bus.done) done_seen++;
    model_step(en, start, stop, pause, periodic, lv);
    @(posedge clk);
    @(negedge clk);
  endtask

  vec_t tbl[$];

  initial begin
    rst          = 1'b0;
    bus.en       = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.pause    = 1'b0;
    bus.periodic = 1'b0;
    bus.loadVal  = '0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_count", int'(bus.count), 0);
    chk("reset_busy",  int'(bus.busy),  0);
    chk("reset_done",  int'(bus.done),  0);
    @(negedge clk);
    rst = 1'b1;

    // Hand-computed vectors: one-shot of 3, then stop/start collisions.
    //         en st sp pa pe lv  cnt busy done
    tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 3,  0, 0, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  3, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  2, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  1, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 1, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{1, 1, 1, 0, 0, 5,  0, 1, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 0,  0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 0, 2,  0, 1, 0});
    tbl.push_back('{0, 0, 0, 0, 0, 0,  2, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 0, 0,  2, 1, 0});
    tbl.push_back('{1, 0, 0, 0, 0, 0,  0, 0, 0});

    foreach (tbl[i]) begin
      bus.en       = tbl[i].en;
      bus.start    = tbl[i].start;
      bus.stop     = tbl[i].stop;
      bus.pause    = tbl[i].pause;
      bus.periodic = tbl[i].periodic;
      bus.loadVal  = tbl[i].lv[N-1:0];
      #1;
      chk("tbl_count", int'(bus.count), tbl[i].exp_count);
      chk("tbl_busy",  int'(bus.busy),  int'(tbl[i].exp_busy));
      chk("tbl_done",  int'(bus.done),  int'(tbl[i].exp_done));
      model_step(tbl[i].en, tbl[i].start, tbl[i].stop, tbl[i].pause,
                 tbl[i].periodic, tbl[i].lv);
      @(posedge clk);
      @(negedge clk);
    end

    // Periodic reload 2 with a tick every third cycle: 4 periods.
    cycle(0, 1, 0, 0, 1, 2);
    done_seen = 0;
    for (int i = 0; i < 36; i++) cycle((i % 3) == 2, 0, 0, 0, 0, 0);
    chk("periodic_sparse_dones", done_seen, 4);
    chk("periodic_sparse_busy", int'(bus.busy), 1);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Pause: load 5, two ticks, freeze for 10 enabled cycles, release.
    cycle(1, 1, 0, 0, 0, 5);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("pause_entry_count", int'(bus.count), 3);
    done_seen = 0;
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("pause_release_count", int'(bus.count), 3);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    chk("pause_pre_expiry_dones", done_seen, 0);
    cycle(1, 0, 0, 0, 0, 0);
    chk("pause_expiry_dones", done_seen, 1);
    cycle(1, 0, 0, 0, 0, 0);

    // loadVal 0 periodic: done every enabled cycle.
    cycle(1, 1, 0, 0, 1, 0);
    done_seen = 0;
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);
    chk("zero_periodic_dones", done_seen, 6);

    // Maximum load: period of 16 ticks.
    cycle(1, 1, 0, 0, 1, 15);
    done_seen = 0;
    for (int i = 0; i < 32; i++) cycle(1, 0, 0, 0, 0, 0);
    chk("max_period_dones", done_seen, 2);
    cycle(0, 0, 1, 0, 0, 0);

    // Asynchronous reset between edges at count 4.
    cycle(1, 1, 0, 0, 0, 7);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    bus.en = 1'b1;
    #1;
    chk("pre_reset_count", int'(bus.count), 4);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_reset_count", int'(bus.count), 0);
    chk("async_reset_busy",  int'(bus.busy),  0);
    chk("async_reset_done",  int'(bus.done),  0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 40) == 0,
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 15)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
- Programmable down-counting timer; the count-down counterpart to the team's up-counting max-value counter.
- Loads a start value, decrements once per enabled tick, and pulses `done` on the tick where it is already at zero.
- One-shot and periodic (auto-reload) modes, plus pause and stop controls.
- Used to time delays and generate periodic strobes from a tick enable (e.g. a prescaler rollover).

Parameters:
N, 4, width of the load value and count.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  asynchronous active-low reset (rst=0 resets immediately)
en  input  1  tick enable; the count changes only on cycles with en=1
start  input  1  single-cycle pulse; loads loadVal and starts or restarts the timer
stop  input  1  single-cycle pulse; aborts and returns to IDLE
pause  input  1  level; while high in RUN, count is frozen
periodic  input  1  sampled with start: 1 = auto-reload, 0 = one-shot
loadVal  input  N  start value; sampled with start
count  output  N  current count value
busy  output  1  1 when state is not IDLE
done  output  1  expiry strobe, combinational, one cycle per expiry

Behaviour:
- State encoding: IDLE, RUN, PAUSED, held in a state register.
- Internal registers: reload[N-1:0] and mode_periodic, both captured on an accepted start.
- Reset (rst=0, asynchronous): state=IDLE, count=0, reload=0, mode_periodic=0. Therefore busy=0 and done=0.
- Priority each cycle: stop > start > pause > en.
- stop, any state:
  - next state IDLE, count<=0.
  - done forced 0 that cycle.
  - reload keeps its value.
- start (with stop=0), any state:
  - count<=loadVal, reload<=loadVal, mode_periodic<=periodic, next state RUN.
  - done forced 0 that cycle; a start in RUN or PAUSED is a restart.
  - pause is not evaluated in the start cycle; it is evaluated on the next cycle.
- RUN, with no start/stop:
  - pause=1: next state PAUSED, count held, done=0. en is ignored that cycle.
  - pause=0, en=0: hold.
  - pause=0, en=1, count!=0: count<=count-1.
  - pause=0, en=1, count==0: expiry.
    - done=1 that same cycle.
    - If mode_periodic=1: count<=reload, stay RUN.
    - Otherwise: next state IDLE, count stays 0.
- PAUSED, with no start/stop:
  - count frozen, done=0.
  - pause=0: next state RUN. en is ignored in that transition cycle.
- IDLE, with no start: count held, en ignored, done=0.
- done is combinational: (state==RUN) & ~pause & en & (count==0) & ~start & ~stop.
- Expiry timing: the expiry takes loadVal+1 enabled ticks after start, counting only en cycles in RUN. This matches the max+1 period of the up-counter.
- loadVal=0:
  - Valid.
  - Expires on the first enabled tick in RUN.
  - Periodic with reload=0 gives done on every enabled tick.
- Wrap-around: the count never decrements below 0; no underflow is possible.
- loadVal at the maximum (all ones) is legal: period 2^N ticks.
- Reset asserted mid-run aborts with no done pulse. After release the timer is IDLE and needs a new start.
- No combinational path from loadVal or periodic to any output.

Test Plan:
1. Reset then one-shot: rst=0→1, start with loadVal=3, periodic=0, en=1 every cycle.
   - count 3,2,1,0 on successive cycles.
   - done=1 on the 4th enabled cycle after start.
   - Then busy=0, count=0.
2. Periodic with sparse ticks: loadVal=2, periodic=1, en=1 every 3rd cycle.
   - done on every 3rd enabled tick, count reloads 2 after each done.
   - busy stays 1 for 4 periods.
   - stop → IDLE, count=0, no done.
3. Pause: loadVal=5, run 2 ticks (count=3), pause=1 for 10 cycles with en=1.
   - count stays 3, done=0.
   - Release pause: the release cycle does not decrement.
   - done on the 4th enabled tick after that.
4. Simultaneous events:
   - stop+start in the same cycle at count=0 with en=1: IDLE, count=0, done=0.
   - start alone in that situation: done=0, count=loadVal, stays RUN.
5. loadVal=0 periodic, en=1 continuous: done=1 every cycle from the first cycle after start; count stays 0. Then loadVal=15 (N=4): 16-tick period.
6. Async reset mid-run: drive rst=0 between clock edges at count=4.
   - count=0, busy=0 immediately without a clock edge.
   - No done pulse.
   - Stays IDLE after release until the next start.
